// File: rtl/hiz_pkg.sv
// Shared encodings, clear-FSM states and helpers for the Hi-Z tile cull stage.
package hiz_pkg;

    localparam logic [1:0] ZF_LESS   = 2'd0;
    localparam logic [1:0] ZF_LEQUAL = 2'd1;
    localparam logic [1:0] ZF_ALWAYS = 2'd2;
    localparam logic [1:0] ZF_NEVER  = 2'd3;

    typedef enum logic [1:0] {
        CLR_IDLE       = 2'd0,
        CLR_WAIT_DRAIN = 2'd1,
        CLR_SWEEP      = 2'd2
    } clr_state_e;

    localparam int POP_MAX_W = 128;

    function automatic logic [7:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/hiz_tile_cull_if.sv
// Request, result and zfar-update channels of the Hi-Z tile cull stage.
interface hiz_tile_cull_if #(
    parameter int PIXELS  = 16,
    parameter int DEPTH_W = 24,
    parameter int TILE_W  = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [TILE_W-1:0]         in_tile;
    logic [PIXELS-1:0]         in_cov;
    logic [PIXELS*DEPTH_W-1:0] in_z;
    logic [1:0]                z_func;
    logic                      out_valid;
    logic                      out_ready;
    logic [TILE_W-1:0]         out_tile;
    logic [PIXELS-1:0]         out_keep;
    logic [PIXELS-1:0]         out_reject;
    logic                      upd_valid;
    logic                      upd_ready;
    logic [TILE_W-1:0]         upd_tile;
    logic [DEPTH_W-1:0]        upd_zfar;

    modport master (
        output in_valid, in_tile, in_cov, in_z, z_func,
        output out_ready, upd_valid, upd_tile, upd_zfar,
        input  in_ready, out_valid, out_tile, out_keep, out_reject,
        input  upd_ready
    );

    modport slave (
        input  in_valid, in_tile, in_cov, in_z, z_func,
        input  out_ready, upd_valid, upd_tile, upd_zfar,
        output in_ready, out_valid, out_tile, out_keep, out_reject,
        output upd_ready
    );
endinterface

// File: rtl/hiz_buf.sv
// One-write/one-read zfar buffer; read data holds when re is low.
module hiz_buf #(
    parameter int DEPTH_W = 24,
    parameter int TILE_W  = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [TILE_W-1:0]  waddr,
    input  logic [DEPTH_W-1:0] wdata,
    input  logic               re,
    input  logic [TILE_W-1:0]  raddr,
    output logic [DEPTH_W-1:0] rdata
);
    localparam int N = 1 << TILE_W;

    logic [DEPTH_W-1:0] mem [N];
    logic [DEPTH_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/hiz_tile_cull.sv
// Hi-Z early reject: per-tile zfar lookup, depth compare, clear sweep, stats.
module hiz_tile_cull #(
    parameter int PIXELS    = 16,
    parameter int DEPTH_W   = 24,
    parameter int NUM_TILES = 256,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    hiz_tile_cull_if.slave     bus,
    input  logic               clr_req,
    input  logic [DEPTH_W-1:0] clr_val,
    output logic               busy,
    output logic [CNT_W-1:0]   reject_cnt
);
    import hiz_pkg::*;

    localparam int TILE_W = $clog2(NUM_TILES);

    clr_state_e state_q, state_d;
    logic [DEPTH_W-1:0] clr_val_q, clr_val_d;
    logic [TILE_W-1:0] sweep_q, sweep_d;

    logic s1_valid_q, s1_valid_d;
    logic [TILE_W-1:0] s1_tile_q, s1_tile_d;
    logic [PIXELS-1:0] s1_cov_q, s1_cov_d;
    logic [PIXELS*DEPTH_W-1:0] s1_z_q, s1_z_d;
    logic [1:0] s1_func_q, s1_func_d;
    logic s1_byp_q, s1_byp_d;
    logic [DEPTH_W-1:0] s1_bz_q, s1_bz_d;

    logic out_valid_q, out_valid_d;
    logic [TILE_W-1:0] out_tile_q, out_tile_d;
    logic [PIXELS-1:0] out_keep_q, out_keep_d;
    logic [PIXELS-1:0] out_reject_q, out_reject_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic advance, in_ready, accept, upd_ready, upd_fire, upd_hit_s1;
    logic sweeping;
    logic buf_we;
    logic [TILE_W-1:0] buf_waddr;
    logic [DEPTH_W-1:0] buf_wdata, rdata, zref;
    logic [PIXELS-1:0] rej;
    logic [7:0] pc;
    logic [CNT_W:0] cnt_sum;

    assign busy       = (state_q != CLR_IDLE);
    assign sweeping   = (state_q == CLR_SWEEP);
    assign advance    = !out_valid_q || bus.out_ready;
    assign in_ready   = !busy && (!s1_valid_q || advance);
    assign accept     = bus.in_valid && in_ready;
    assign upd_ready  = !sweeping;
    assign upd_fire   = bus.upd_valid && upd_ready;
    assign upd_hit_s1 = upd_fire && s1_valid_q && (bus.upd_tile == s1_tile_q);

    // Sweep and update never collide: updates are back-pressured while sweeping.
    assign buf_we    = sweeping || upd_fire;
    assign buf_waddr = sweeping ? sweep_q : bus.upd_tile;
    assign buf_wdata = sweeping ? clr_val_q : bus.upd_zfar;

    hiz_buf #(
        .DEPTH_W(DEPTH_W),
        .TILE_W (TILE_W)
    ) u_buf (
        .clk  (clk),
        .we   (buf_we),
        .waddr(buf_waddr),
        .wdata(buf_wdata),
        .re   (accept),
        .raddr(bus.in_tile),
        .rdata(rdata)
    );

    // Most recent update to the S1 tile wins over the (older) buffer read.
    assign zref = upd_hit_s1 ? bus.upd_zfar :
                  s1_byp_q   ? s1_bz_q    : rdata;

    always_comb begin
        rej = '0;
        for (int i = 0; i < PIXELS; i++) begin
            logic [DEPTH_W-1:0] zl;
            logic hit;
            zl = s1_z_q[i*DEPTH_W +: DEPTH_W];
            hit = 1'b0;
            unique case (s1_func_q)
                ZF_LESS:   hit = (zl >= zref);
                ZF_LEQUAL: hit = (zl > zref);
                ZF_ALWAYS: hit = 1'b0;
                default:   hit = 1'b1;
            endcase
            rej[i] = s1_cov_q[i] & hit;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_tile_d  = s1_tile_q;
        s1_cov_d   = s1_cov_q;
        s1_z_d     = s1_z_q;
        s1_func_d  = s1_func_q;
        s1_byp_d   = s1_byp_q;
        s1_bz_d    = s1_bz_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_tile_d  = bus.in_tile;
            s1_cov_d   = bus.in_cov;
            s1_z_d     = bus.in_z;
            s1_func_d  = bus.z_func;
            s1_byp_d   = upd_fire && (bus.upd_tile == bus.in_tile);
            s1_bz_d    = bus.upd_zfar;
        end else begin
            if (advance) begin
                s1_valid_d = 1'b0;
            end
            if (upd_hit_s1) begin
                s1_byp_d = 1'b1;
                s1_bz_d  = bus.upd_zfar;
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_tile_d   = out_tile_q;
        out_keep_d   = out_keep_q;
        out_reject_d = out_reject_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_tile_d   = s1_tile_q;
                out_keep_d   = s1_cov_q & ~rej;
                out_reject_d = rej;
            end
        end
    end

    always_comb begin
        pc      = popcount(POP_MAX_W'(out_reject_q));
        cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(pc);
        cnt_d   = cnt_q;
        if (out_valid_q && bus.out_ready) begin
            cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_val_d = clr_val_q;
        sweep_d   = sweep_q;
        unique case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    clr_val_d = clr_val;
                    state_d   = CLR_WAIT_DRAIN;
                end
            end
            CLR_WAIT_DRAIN: begin
                if (!s1_valid_q && !out_valid_q) begin
                    sweep_d = '0;
                    state_d = CLR_SWEEP;
                end
            end
            CLR_SWEEP: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == TILE_W'(NUM_TILES-1)) begin
                    state_d = CLR_IDLE;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CLR_SWEEP;
            clr_val_q    <= '1;
            sweep_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_tile_q    <= '0;
            s1_cov_q     <= '0;
            s1_z_q       <= '0;
            s1_func_q    <= '0;
            s1_byp_q     <= 1'b0;
            s1_bz_q      <= '0;
            out_valid_q  <= 1'b0;
            out_tile_q   <= '0;
            out_keep_q   <= '0;
            out_reject_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            clr_val_q    <= clr_val_d;
            sweep_q      <= sweep_d;
            s1_valid_q   <= s1_valid_d;
            s1_tile_q    <= s1_tile_d;
            s1_cov_q     <= s1_cov_d;
            s1_z_q       <= s1_z_d;
            s1_func_q    <= s1_func_d;
            s1_byp_q     <= s1_byp_d;
            s1_bz_q      <= s1_bz_d;
            out_valid_q  <= out_valid_d;
            out_tile_q   <= out_tile_d;
            out_keep_q   <= out_keep_d;
            out_reject_q <= out_reject_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.upd_ready  = upd_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_tile   = out_tile_q;
    assign bus.out_keep   = out_keep_q;
    assign bus.out_reject = out_reject_q;
    assign reject_cnt     = cnt_q;
endmodule

// File: tb/tb_hiz_tile_cull.sv
// Scoreboard bench for hiz_tile_cull: compare, bypass, stall, clear, saturation.
module tb_hiz_tile_cull;
    localparam int PIX = 16;
    localparam int DW  = 24;
    localparam int NT  = 256;
    localparam int TW  = 8;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          clr_req = 1'b0;
    logic [DW-1:0] clr_val = '0;
    logic          busy;
    logic [CW-1:0] reject_cnt;

    hiz_tile_cull_if #(.PIXELS(PIX), .DEPTH_W(DW), .TILE_W(TW)) bus ();

    hiz_tile_cull #(
        .PIXELS(PIX), .DEPTH_W(DW), .NUM_TILES(NT), .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clr_req   (clr_req),
        .clr_val   (clr_val),
        .busy      (busy),
        .reject_cnt(reject_cnt)
    );

    typedef struct {
        logic [TW-1:0]  tile;
        logic [PIX-1:0] keep;
        logic [PIX-1:0] rej;
    } exp_t;

    exp_t sbq[$];
    logic [DW-1:0] zm [NT];
    int errors  = 0;
    int checks  = 0;
    int pushes  = 0;
    int pops    = 0;
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [TW-1:0] t,
                                   input logic [PIX-1:0] cov,
                                   input logic [PIX*DW-1:0] z,
                                   input logic [1:0] f,
                                   input logic [DW-1:0] zr);
        exp_t e;
        e.tile = t;
        e.rej  = '0;
        for (int i = 0; i < PIX; i++) begin
            logic [DW-1:0] zi;
            logic r;
            zi = z[i*DW +: DW];
            case (f)
                2'd0:    r = (zi >= zr);
                2'd1:    r = (zi > zr);
                2'd2:    r = 1'b0;
                default: r = 1'b1;
            endcase
            e.rej[i] = cov[i] && r;
        end
        e.keep = cov & ~e.rej;
        return e;
    endfunction

    function automatic logic [PIX*DW-1:0] mkz(input logic [DW-1:0] z0,
                                              input logic [DW-1:0] z1,
                                              input logic [DW-1:0] zr);
        logic [PIX*DW-1:0] v;
        for (int i = 0; i < PIX; i++) begin
            v[i*DW +: DW] = (i == 0) ? z0 : (i == 1) ? z1 : zr;
        end
        return v;
    endfunction

    function automatic logic [PIX*DW-1:0] mkrand();
        logic [PIX*DW-1:0] v;
        for (int i = 0; i < PIX; i++) begin
            v[i*DW +: DW] = DW'($urandom);
        end
        return v;
    endfunction

    // Handshake observer: updates the zfar model, pushes and pops the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.upd_valid && bus.upd_ready) begin
                zm[bus.upd_tile] = bus.upd_zfar;
            end
            if (bus.in_valid && bus.in_ready) begin
                sbq.push_back(model(bus.in_tile, bus.in_cov, bus.in_z,
                                    bus.z_func, zm[bus.in_tile]));
                pushes++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", 64'(sbq.size()), 64'd1);
                end else begin
                    e = sbq.pop_front();
                    pops++;
                    chk("out_tile", 64'(bus.out_tile), 64'(e.tile));
                    chk("out_keep", 64'(bus.out_keep), 64'(e.keep));
                    chk("out_reject", 64'(bus.out_reject), 64'(e.rej));
                    exp_cnt = exp_cnt + $countones(e.rej);
                    if (exp_cnt > 255) exp_cnt = 255;
                end
            end
        end
    end

    task automatic send(input logic [TW-1:0] t, input logic [PIX-1:0] cov,
                        input logic [PIX*DW-1:0] z, input logic [1:0] f);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_tile  = t;
        bus.in_cov   = cov;
        bus.in_z     = z;
        bus.z_func   = f;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("send_accepted", 64'(ok), 64'd1);
    endtask

    task automatic upd(input logic [TW-1:0] t, input logic [DW-1:0] z);
        bit ok = 1'b0;
        bus.upd_valid = 1'b1;
        bus.upd_tile  = t;
        bus.upd_zfar  = z;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            ok = bus.upd_ready;
            @(posedge clk);
            #1;
        end
        bus.upd_valid = 1'b0;
        chk("upd_accepted", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = (sbq.size() == 0);
        end
        chk("drain_done", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int need;
        int c;
        logic [PIX:0] m;

        bus.in_valid  = 1'b0;
        bus.in_tile   = '0;
        bus.in_cov    = '0;
        bus.in_z      = '0;
        bus.z_func    = 2'd0;
        bus.out_ready = 1'b1;
        bus.upd_valid = 1'b0;
        bus.upd_tile  = '0;
        bus.upd_zfar  = '0;
        for (int i = 0; i < NT; i++) zm[i] = '1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_tile", 64'(bus.out_tile), 64'd0);
        chk("rst_out_keep", 64'(bus.out_keep), 64'd0);
        chk("rst_out_reject", 64'(bus.out_reject), 64'd0);
        chk("rst_upd_ready", 64'(bus.upd_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_cnt", 64'(reject_cnt), 64'd0);
        rst = 1'b0;

        n = 0;
        while (!bus.in_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == NT / 2) chk("sweep_upd_ready", 64'(bus.upd_ready), 64'd0);
        end
        chk("init_sweep_len", 64'(n), 64'(NT));
        chk("idle_upd_ready", 64'(bus.upd_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        upd(8'd5, 24'h100000);
        send(8'd5, 16'hFFFF, mkz(24'h0FFFFF, 24'h200000, 24'h200000), 2'd0);
        drain();
        chk("cnt_first", 64'(reject_cnt), 64'd15);

        send(8'd5, 16'hFFFF, mkz(24'h0FFFFF, 24'h100000, 24'h200000), 2'd1);
        send(8'd5, 16'hFFFF, mkz(24'h0FFFFF, 24'h100000, 24'h200000), 2'd2);
        send(8'd5, 16'h00F0, mkz(24'h0FFFFF, 24'h100000, 24'h200000), 2'd3);
        drain();
        chk("cnt_funcs", 64'(reject_cnt), 64'(exp_cnt));

        // Update and request to the same tile in one cycle.
        bus.upd_valid = 1'b1;
        bus.upd_tile  = 8'd7;
        bus.upd_zfar  = 24'd0;
        bus.in_valid  = 1'b1;
        bus.in_tile   = 8'd7;
        bus.in_cov    = 16'hFFFF;
        bus.in_z      = mkz(24'd1, 24'd1, 24'd1);
        bus.z_func    = 2'd0;
        @(negedge clk);
        chk("byp_in_ready", 64'(bus.in_ready), 64'd1);
        chk("byp_upd_ready", 64'(bus.upd_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        bus.in_valid  = 1'b0;
        drain();

        upd(8'd10, 24'h800000);
        upd(8'd12, 24'h000100);
        bus.out_ready = 1'b0;
        fork
            begin
                send(8'd10, 16'hFFFF, mkrand(), 2'd0);
                send(8'd11, 16'h0F0F, mkrand(), 2'd1);
                send(8'd12, 16'hFFFF, mkrand(), 2'd0);
                send(8'd13, 16'h3C3C, mkrand(), 2'd3);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
                chk("stall_out_tile", 64'(bus.out_tile), 64'd10);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("cnt_stall", 64'(reject_cnt), 64'(exp_cnt));

        bus.out_ready = 1'b0;
        send(8'd5, 16'hFFFF, mkz(24'h0FFFFF, 24'h200000, 24'h200000), 2'd0);
        send(8'd7, 16'hFFFF, mkrand(), 2'd0);
        clr_req = 1'b1;
        clr_val = '0;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        for (int i = 0; i < NT; i++) zm[i] = '0;
        chk("clr_busy", 64'(busy), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        n = 0;
        k = 0;
        while (busy && k < 2000) begin
            @(negedge clk);
            if (busy && !bus.out_valid && sbq.size() == 0) n++;
            k++;
        end
        chk("clr_busy_len", 64'(n), 64'(NT + 1));
        @(posedge clk);
        #1;
        send(8'd9, 16'hFFFF, mkrand(), 2'd0);
        drain();
        chk("cnt_clear", 64'(reject_cnt), 64'(exp_cnt));

        need = 250 - exp_cnt;
        while (need > 0) begin
            c = (need >= 16) ? 16 : need;
            m = (17'd1 << c) - 17'd1;
            send(8'd3, m[PIX-1:0], mkrand(), 2'd3);
            need = need - c;
        end
        drain();
        chk("cnt_250", 64'(reject_cnt), 64'd250);
        send(8'd3, 16'hFFFF, mkrand(), 2'd3);
        drain();
        chk("cnt_sat", 64'(reject_cnt), 64'd255);
        chk("cnt_model", 64'(reject_cnt), 64'(exp_cnt));

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        chk("push_pop", 64'(pops), 64'(pushes));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hiz_tile_cull.md
# hiz_tile_cull

Parametrised hierarchical-Z early-reject stage. It sits between the rasteriser tile walker and the fragment shader launch. It holds one conservative far-depth value (zfar) per screen tile in an on-chip buffer and compares each incoming tile's fragment depths against that tile's entry under a selectable depth function. The ROP/late-Z path refreshes entries through an update port, and a sweep engine clears the buffer after reset or on request.

## Interface
- PIXELS, 16, fragments per tile request
- DEPTH_W, 24, unsigned fixed-point depth width
- NUM_TILES, 256, Hi-Z entries (power of two); TILE_W = log2(NUM_TILES)
- CNT_W, 32, reject statistics counter width
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  tile request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_tile  in  TILE_W  tile index
- in_cov  in  PIXELS  coverage mask
- in_z  in  PIXELS*DEPTH_W  fragment depths; lane i occupies [i*DEPTH_W +: DEPTH_W]
- z_func  in  2  0 LESS, 1 LEQUAL, 2 ALWAYS, 3 NEVER; sampled with each request
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_tile  out  TILE_W  echoed tile index
- out_keep  out  PIXELS  surviving fragments
- out_reject  out  PIXELS  covered fragments rejected
- upd_valid  in  1  zfar write request
- upd_ready  out  1  low while clearing
- upd_tile  in  TILE_W  entry to write
- upd_zfar  in  DEPTH_W  new zfar, written unconditionally
- clr_req  in  1  single-cycle clear request
- clr_val  in  DEPTH_W  clear value
- busy  out  1  clear pending or in progress
- reject_cnt  out  CNT_W  saturating count of rejected fragments

## Operation
- Reject rule per lane, with zref as the stored entry:
  - LESS: reject when cov[i] && z[i] >= zref.
  - LEQUAL: reject when cov[i] && z[i] > zref.
  - ALWAYS: reject nothing.
  - NEVER: reject every covered lane.
- out_keep = in_cov & ~out_reject. Uncovered lanes are 0 in both masks.
- All compares are unsigned DEPTH_W-bit.
- Pipeline stages:
  - S1 holds the accepted request while the buffer read is in flight.
  - S2 is the output register.
  - advance = !out_valid || out_ready.
  - in_ready = !busy && (!s1_valid || advance).
  - The buffer read enable equals the accept strobe. Read data is held while the pipeline is stalled.
- Update port:
  - Fires when upd_valid && upd_ready and writes the buffer that cycle.
  - Bypass: if an update fires to the tile held in S1 (including the cycle S1 loads), the S1 compare uses the latest such upd_zfar instead of the buffer data.
  - A request accepted in the cycle after an update completes reads the new value.
- Clear FSM:
  - States: IDLE, WAIT_DRAIN, SWEEP.
  - clr_req in IDLE: latch clr_val and go to WAIT_DRAIN. busy=1 from the next cycle.
  - WAIT_DRAIN: move to SWEEP once S1 and S2 are empty.
  - SWEEP: write one entry per cycle, address 0 to NUM_TILES-1, then return to IDLE and drop busy.
  - clr_req outside IDLE is ignored.
  - upd_ready = (state != SWEEP). Updates during WAIT_DRAIN are legal.
- Reset:
  - Clear value is set to all-ones and the FSM enters SWEEP directly, so a full initialisation happens automatically.
  - Buffer contents themselves are not reset.
- Statistics: reject_cnt adds popcount(out_reject) on each output handshake and saturates at all-ones.

## Timing
- Reset values: in_ready 0, out_valid 0, out_tile 0, out_keep 0, out_reject 0, upd_ready 1 only after the first sweep ends (0 during reset sweep), busy 1, reject_cnt 0.
- Latency: a request accepted in cycle N presents out_valid in N+2 when unstalled.
- Throughput: one request per cycle.
- Output fields stay stable while out_valid && !out_ready.
- Post-reset sweep takes NUM_TILES cycles; in_ready first rises at cycle NUM_TILES after reset release.
- A user clear with an empty pipeline takes NUM_TILES+1 busy cycles.
- Reset asserted mid-sweep or mid-stall: all pipeline valids drop immediately, then the initialisation sweep restarts from address 0.

## Structure
- Shared package hiz_pkg holds:
  - z_func encodings (ZF_LESS, ZF_LEQUAL, ZF_ALWAYS, ZF_NEVER);
  - the clear FSM state enum;
  - a popcount function.
- Sub-module hiz_buf: one-write/one-read synchronous buffer with read enable and hold. Its write port is muxed between the sweep and update paths.

## Test plan
- Reset, then entry 5 loaded to 0x100000 via update; LESS request on tile 5 with cov=0xFFFF and lane0 z=0x0FFFFF, others 0x200000 → out_keep=0x0001, out_reject=0xFFFE, reject_cnt=15.
- Same depths under LEQUAL with lane1 z=0x100000 → lane1 kept. Under ALWAYS → out_reject=0. Under NEVER with cov=0x00F0 → out_reject=0x00F0.
- upd_tile=7, upd_zfar=0 issued in the same cycle as a request on tile 7 is accepted (all z=1, LESS) → all covered lanes rejected via bypass.
- out_ready held low for 5 cycles with back-to-back requests → in_ready drops once S1 and S2 are full, no result lost or duplicated, order preserved.
- clr_req with clr_val=0 while two requests are in flight → both drain with old values, busy spans NUM_TILES+1 cycles after drain, and a subsequent LESS request rejects every covered lane.
- reject_cnt preset near all-ones (CNT_W=8 build, 250 rejects then 16 more) → saturates at 255.
